// File: rtl/booth_mul_seq_pkg.sv
// mul_pkg: shared types and helpers for the radix-4 Booth multiplier
package mul_pkg;
   typedef enum logic [1:0] {MUL_LO = 2'b00, MUL_H = 2'b01, MUL_HSU = 2'b10, MUL_HU = 2'b11} mul_op_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
   // s: negate, c: select 2A instead of A, z: digit is zero
   typedef struct packed {
      logic s;
      logic c;
      logic z;
   } booth_digit_t;
   function automatic int mul_iters(input int xlen);
      return (xlen + 2) / 2;
   endfunction
   function automatic booth_digit_t booth_decode(input logic [2:0] d);
      booth_digit_t r;
      r.z = (d == 3'b000) || (d == 3'b111);
      r.c = (d == 3'b011) || (d == 3'b100);
      r.s = d[2] & ~(d[1] & d[0]);
      return r;
   endfunction
endpackage

// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: operand request and result handshakes of the multiplier
interface booth_mul_seq_if #(parameter int XLEN = 32);
   import mul_pkg::*;
   logic            i_valid;
   logic            o_ready;
   mul_op_t         i_op;
   logic [XLEN-1:0] i_data_a;
   logic [XLEN-1:0] i_data_b;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_data;
   modport slave (input i_valid, i_op, i_data_a, i_data_b, i_ready, output o_ready, o_valid, o_data);
   modport master (output i_valid, i_op, i_data_a, i_data_b, i_ready, input o_ready, o_valid, o_data);
endinterface

// File: rtl/booth_mul_seq_pp_row.sv
// booth_pp_row: one Booth partial-product row added onto the accumulator high slice
module booth_pp_row import mul_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [XLEN+1:0] a_i,
   input  logic [2:0]      digit_i,
   input  logic [XLEN+3:0] acc_i,
   output logic [XLEN+3:0] sum_o
);
   localparam int HW = XLEN + 4;
   booth_digit_t d;
   logic [HW:0]   a_x;
   logic [HW-1:0] pp;
   assign d   = booth_decode(digit_i);
   // sign-extended A with a zero appended below bit 0 so a_x[j] is A[j-1] (the 2A tap)
   assign a_x = {{2{a_i[XLEN+1]}}, a_i, 1'b0};
   for (genvar j = 0; j < HW; j++) begin : g_cell
      assign pp[j] = ~d.z & ((d.c ? a_x[j] : a_x[j+1]) ^ d.s);
   end
   assign sum_o = acc_i + pp + {{(HW-1){1'b0}}, d.s};
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU
module booth_mul_seq import mul_pkg::*; #(
   parameter int XLEN       = 32,
   parameter bit EARLY_ZERO = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   booth_mul_seq_if.slave      bus
);
   localparam int N  = mul_iters(XLEN);
   localparam int HW = XLEN + 4;
   localparam int LW = XLEN + 2;
   localparam int AW = HW + LW;
   localparam int CW = $clog2(N);
   mul_state_t             state_q;
   mul_op_t                op_q;
   logic [CW-1:0]          cnt_q;
   logic [LW-1:0]          a_q;
   logic                   b_prev_q;
   // high HW bits collect partial sums, low LW bits start as the multiplier and fill with product bits
   logic signed [AW-1:0]   acc_q;
   logic signed [AW-1:0]   acc_d;
   logic [HW-1:0]          sum;
   logic [LW-1:0]          a_ext;
   logic [LW-1:0]          b_ext;
   logic [XLEN-1:0]        res_d;
   logic                   zero;
   logic                   o_ready_q;
   logic                   o_valid_q;
   logic [XLEN-1:0]        o_data_q;
   assign a_ext = {{2{bus.i_data_a[XLEN-1] & (bus.i_op == MUL_H || bus.i_op == MUL_HSU)}}, bus.i_data_a};
   assign b_ext = {{2{bus.i_data_b[XLEN-1] & (bus.i_op == MUL_H)}}, bus.i_data_b};
   assign zero  = EARLY_ZERO && (bus.i_data_a == '0 || bus.i_data_b == '0);
   booth_pp_row #(.XLEN(XLEN)) u_row (
      .a_i     (a_q),
      .digit_i ({acc_q[1:0], b_prev_q}),
      .acc_i   (acc_q[AW-1:LW]),
      .sum_o   (sum)
   );
   assign acc_d = $signed({sum, acc_q[LW-1:0]}) >>> 2;
   assign res_d = (op_q == MUL_LO) ? acc_d[XLEN-1:0] : acc_d[2*XLEN-1:XLEN];
   assign bus.o_ready = o_ready_q;
   assign bus.o_valid = o_valid_q;
   assign bus.o_data  = o_data_q;
   // control FSM, operand latch, one Booth digit per BUSY cycle and registered handshake outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         op_q      <= MUL_LO;
         cnt_q     <= '0;
         a_q       <= '0;
         b_prev_q  <= 1'b0;
         acc_q     <= '0;
         o_ready_q <= 1'b1;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
      end else if (i_flush) begin
         state_q   <= IDLE;
         o_ready_q <= 1'b1;
         o_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.i_valid) begin
               state_q   <= BUSY;
               o_ready_q <= 1'b0;
               op_q      <= bus.i_op;
               a_q       <= a_ext;
               acc_q     <= {{HW{1'b0}}, zero ? {LW{1'b0}} : b_ext};
               b_prev_q  <= 1'b0;
               cnt_q     <= zero ? CW'(N-1) : '0;
            end
            BUSY: begin
               acc_q    <= acc_d;
               b_prev_q <= acc_q[1];
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(N-1)) begin
                  state_q   <= DONE;
                  o_valid_q <= 1'b1;
                  o_data_q  <= res_d;
                  cnt_q     <= '0;
               end
            end
            DONE: if (bus.i_ready) begin
               state_q   <= IDLE;
               o_valid_q <= 1'b0;
               o_ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and random checks of booth_mul_seq against a 64-bit arithmetic model
module tb_booth_mul_seq;
   import mul_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;
   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];
   booth_mul_seq_if #(.XLEN(32)) bus ();
   booth_mul_seq #(.XLEN(32), .EARLY_ZERO(1'b1)) dut (.i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ax, bx, p;
      ax = (op == MUL_H || op == MUL_HSU) ? {{32{a[31]}}, a} : {32'b0, a};
      bx = (op == MUL_H) ? {{32{b[31]}}, b} : {32'b0, b};
      p = ax * bx;
      return (op == MUL_LO) ? p[31:0] : p[63:32];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus.o_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!bus.o_valid) begin
         total++;
         bad++;
         $display("FAIL timeout: o_valid not seen within 40 cycles");
      end
   endtask

   task automatic do_op(input mul_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit,
                        input bit use_lit, input int lat, input int hold);
      int cyc;
      logic [31:0] d0;
      chk("ready_before_accept", 32'(bus.o_ready), 32'd1);
      bus.i_valid = 1'b1; bus.i_op = op; bus.i_data_a = a; bus.i_data_b = b;
      exp_q.push_back(ref_mul(op, a, b));
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      bus.i_data_a = $urandom; bus.i_data_b = $urandom;
      bus.i_op = mul_op_t'(2'($urandom_range(0, 3)));
      wait_valid(cyc);
      chk("latency", 32'(cyc), 32'(lat));
      d0 = bus.o_data;
      if (use_lit) chk("literal_result", d0, lit);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(bus.o_valid), 32'd1);
         chk("hold_data", bus.o_data, d0);
         chk("hold_not_ready", 32'(bus.o_ready), 32'd0);
      end
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      chk("valid_dropped", 32'(bus.o_valid), 32'd0);
      chk("back_to_idle", 32'(bus.o_ready), 32'd1);
   endtask

   // every cycle a result is offered it must match the model and never coexist with o_ready
   always @(negedge clk) begin
      if (!rst && bus.o_valid) begin
         chk("valid_ready_exclusive", 32'(bus.o_ready), 32'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %h with no request outstanding", bus.o_data);
         end else begin
            chk("model_result", bus.o_data, exp_q[0]);
            if (bus.i_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int cyc;
      logic [31:0] ra, rb;
      bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_op = MUL_LO; bus.i_data_a = '0; bus.i_data_b = '0;
      #1 rst = 1'b1;
      #2;
      chk("reset_ready", 32'(bus.o_ready), 32'd1);
      chk("reset_valid", 32'(bus.o_valid), 32'd0);
      chk("reset_data", bus.o_data, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(MUL_LO,  32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, 17, 0);
      do_op(MUL_H,   32'h80000000,  32'h80000000, 32'h40000000, 1'b1, 17, 0);
      do_op(MUL_HU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 17, 0);
      do_op(MUL_HSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 17, 0);
      do_op(MUL_LO,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001, 1'b1, 17, 0);
      do_op(MUL_LO,  32'd12345,     32'd678,      32'h007FB6F6, 1'b1, 17, 5);
      do_op(MUL_LO,  32'd0,         32'h00001234, 32'h00000000, 1'b1, 1, 0);
      do_op(MUL_HU,  32'hDEADBEEF,  32'd0,        32'h00000000, 1'b1, 1, 2);
      // flush in the middle of an operation, then flush held while a request is offered
      bus.i_valid = 1'b1; bus.i_op = MUL_H; bus.i_data_a = 32'h12345678; bus.i_data_b = 32'h9ABCDEF0;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      chk("flush_busy_ready", 32'(bus.o_ready), 32'd1);
      chk("flush_busy_valid", 32'(bus.o_valid), 32'd0);
      bus.i_valid = 1'b1; bus.i_op = MUL_LO; bus.i_data_a = 32'd9; bus.i_data_b = 32'd9;
      @(posedge clk); #1;
      flush = 1'b0; bus.i_valid = 1'b0;
      chk("flush_blocks_accept", 32'(bus.o_ready), 32'd1);
      do_op(MUL_HU, 32'd3, 32'd5, 32'h00000000, 1'b1, 17, 0);
      // flush while a result is waiting: result withdrawn, data register untouched
      bus.i_valid = 1'b1; bus.i_op = MUL_LO; bus.i_data_a = 32'd6; bus.i_data_b = 32'd7;
      exp_q.push_back(ref_mul(MUL_LO, 32'd6, 32'd7));
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      wait_valid(cyc);
      chk("flush_done_result", bus.o_data, 32'd42);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      exp_q.delete();
      chk("flush_done_valid", 32'(bus.o_valid), 32'd0);
      chk("flush_done_data_kept", bus.o_data, 32'd42);
      chk("flush_done_ready", 32'(bus.o_ready), 32'd1);
      // asynchronous reset in the middle of an operation
      bus.i_valid = 1'b1; bus.i_op = MUL_HU; bus.i_data_a = 32'hFFFF1234; bus.i_data_b = 32'h00005678;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_busy_ready", 32'(bus.o_ready), 32'd1);
      chk("rst_busy_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_busy_data", bus.o_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(MUL_H, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 1'b1, 17, 0);
      // random sweep across all four ops with a few corner operands mixed in
      for (int k = 0; k < 32; k++) begin
         ra = $urandom;
         rb = $urandom;
         if (k % 8 == 5) ra = 32'h80000000;
         if (k % 8 == 6) rb = 32'hFFFFFFFF;
         if (k % 8 == 7) rb = 32'h7FFFFFFF;
         do_op(mul_op_t'(2'(k % 4)), ra, rb, 32'd0, 1'b0, (ra == 0 || rb == 0) ? 1 : 17, k % 3);
      end
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
